mdio_mgmt_ctrl: RTL and testbench
=================================

Name: mdio_mgmt_ctrl

Overview:
MDIO station-management controller that drives the MDIO receiver block. It arbitrates transaction requests from two host ports using round-robin. It generates MDC from the system clock and serializes clause-22 frames onto MDIO_OUT/MDIO_OE. For reads it releases the bus and captures the PHY's 16-bit reply from MDIO_IN, then returns a one-cycle response to the granted port.

Parameters:
DIV_HALF, 2, CLK cycles per MDC half-period (>=1); MDC period = 2*DIV_HALF CLK cycles
PREAMBLE_LEN, 32, number of '1' preamble bits sent before ST (0 allowed)

Ports:
CLK  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
REQ0_VALID / REQ1_VALID  in  1  request pending; fields held stable until matching READY
REQ0_RW / REQ1_RW  in  1  1=write, 0=read
REQ0_PHY / REQ1_PHY  in  5  PHY address
REQ0_REG / REQ1_REG  in  5  register address
REQ0_WDATA / REQ1_WDATA  in  16  write data (ignored for reads)
REQ0_READY / REQ1_READY  out  1  one-CLK grant pulse; request fields latched in this cycle
RSP0_VALID / RSP1_VALID  out  1  one-CLK completion pulse
RSP0_RDATA / RSP1_RDATA  out  16  read data; valid with RSPn_VALID; 0 for writes
MDC  out  1  management clock, free-running after reset
MDIO_OUT  out  1  serial data to receiver
MDIO_OE  out  1  1 = controller drives MDIO
MDIO_IN  in  1  serial data from receiver/PHY
BUSY  out  1  transaction in progress

Behaviour:
- Reset (reset=0, async): MDC=0, MDIO_OUT=0, MDIO_OE=0, all READY/RSP_VALID=0, RSP_RDATA=0, BUSY=0, state IDLE, RR pointer favours port 0, divider counter=0.
- Divider: counter 0..DIV_HALF-1. On wrap, MDC toggles. "Fall tick" = CLK cycle where MDC goes 1->0; "rise tick" = 0->1. MDIO_OUT/MDIO_OE change only on fall ticks. Receiver samples on MDC rising.
- Frame, MSB first: PREAMBLE_LEN x '1', ST=01, OP (write 01 / read 10), PHY[4:0], REG[4:0], TA, DATA[15:0]. Write TA = 10 driven. Read TA + DATA are undriven by the controller.
- States: IDLE -> PRE (skipped if PREAMBLE_LEN=0) -> HDR (14 bits) -> TA (2 bits) -> DATA (16 bits) -> IDLE. Each bit occupies exactly one MDC period, from fall tick to fall tick.
- Arbitration: evaluated only in IDLE on a fall tick. If exactly one VALID, grant it. If both, grant the port opposite the last granted one. The grant asserts READY for that CLK cycle, latches the fields, sets BUSY=1, and drives the first frame bit with MDIO_OE=1 on that same fall tick.
- MDIO_OE=1 during PRE, HDR and write TA/DATA. On reads, MDIO_OE=0 and MDIO_OUT=0 from the first TA fall tick through the end of DATA.
- Read capture: on each rise tick in DATA, shift MDIO_IN into the read register MSB first (16 samples).
- Completion: on the fall tick ending the last DATA bit:
  - MDIO_OE=0, MDIO_OUT=0, BUSY=0.
  - RSPn_VALID=1 for one CLK with RSPn_RDATA (write: 0).
  - The state returns to IDLE.
  - Arbitration may grant a new request on this same fall tick, giving back-to-back frames with no idle bit.
- Latency: the response arrives exactly (PREAMBLE_LEN+32)*2*DIV_HALF CLK cycles after READY.
- VALID deasserted before READY: the request is simply not considered. VALID held after READY is treated as a new request.
- RSPn_RDATA holds its value until the next response on that port.
- Reset mid-frame: abort immediately, no RSP pulse, all outputs to reset values. A new request is accepted normally after reset release.

Test Plan:
1. DIV_HALF=2, PREAMBLE_LEN=0; REQ0 write PHY=5'b01000 REG=5'b10100 WDATA=16'h5555 -> MDIO_OUT on rise ticks = 01 01 01000 10100 10 0101010101010101; MDIO_OE=1 for 32 MDC periods; RSP0_VALID 128 CLK after READY, RSP0_RDATA=0.
2. REQ1 read PHY=8 REG=20; bench drives MDIO_IN=16'hAAAA MSB first once MDIO_OE=0 after the TA bits -> MDIO_OE drops after 14 header bits; RSP1_VALID with RSP1_RDATA=16'hAAAA; BUSY=0 afterwards.
3. After reset, REQ0 and REQ1 both valid and held -> grant order 0,1,0,1; each READY one CLK wide; responses on the matching port only.
4. PREAMBLE_LEN=32, write -> 32 ones precede 01; response 256 CLK after READY (DIV_HALF=2).
5. Assert reset during DATA of a read -> MDC=0, MDIO_OE=0, BUSY=0, no RSP pulse; the next request after release completes correctly.
6. REQ0 VALID held continuously with REQ1 idle -> consecutive grants to port 0 on completion fall ticks, no gap bit between frames.

Source files
------------

// File: rtl/mdio_mgmt_ctrl.sv
// mdio_mgmt_ctrl: clause-22 MDIO station-management controller.
// Two host request ports share one MDIO bus through a round-robin arbiter.
// MDC is divided down from CLK. Write frames are fully driven. For read
// frames the bus is released from TA onwards, and the PHY's 16-bit reply is
// shifted in on MDC rising edges.
//
// Ports:
//   CLK, reset                     system clock, async active-low reset
//   REQn_VALID/RW/PHY/REG/WDATA    host request n (n = 0, 1); fields held until READY
//   REQn_READY                     one-CLK grant pulse
//   RSPn_VALID, RSPn_RDATA         one-CLK completion pulse and read data (0 for writes)
//   MDC, MDIO_OUT, MDIO_OE         management clock and serial bus drive
//   MDIO_IN                        serial data returned by the PHY
//   BUSY                           frame in progress
module mdio_mgmt_ctrl #(
    parameter int DIV_HALF     = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        REQ0_VALID,
    input  logic        REQ0_RW,
    input  logic [4:0]  REQ0_PHY,
    input  logic [4:0]  REQ0_REG,
    input  logic [15:0] REQ0_WDATA,
    output logic        REQ0_READY,
    output logic        RSP0_VALID,
    output logic [15:0] RSP0_RDATA,
    input  logic        REQ1_VALID,
    input  logic        REQ1_RW,
    input  logic [4:0]  REQ1_PHY,
    input  logic [4:0]  REQ1_REG,
    input  logic [15:0] REQ1_WDATA,
    output logic        REQ1_READY,
    output logic        RSP1_VALID,
    output logic [15:0] RSP1_RDATA,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    input  logic        MDIO_IN,
    output logic        BUSY
);
    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);
    localparam logic [15:0]   PRE_LAST = (PREAMBLE_LEN > 0) ? 16'(PREAMBLE_LEN - 1) : 16'd0;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic          mdc_q;
    logic [15:0]   cnt_q;      // bits already completed in the current state
    logic [31:0]   frame_q;    // remaining ST..DATA bits, next bit at [31]
    logic          rw_q;
    logic          port_q;
    logic          last_q;     // last granted port; 1 after reset so port 0 wins first
    logic [15:0]   rsh_q;      // read shift register
    logic          out_q, oe_q, busy_q;
    logic          rdy0_q, rdy1_q, rv0_q, rv1_q;
    logic [15:0]   rd0_q, rd1_q;

    logic        wrap, fall_tick, rise_tick, free_slot, start, gnt1;
    logic [31:0] new_frame;

    always_comb begin
        wrap      = (div_q == DIV_LAST);
        fall_tick = wrap & mdc_q;
        rise_tick = wrap & ~mdc_q;
        // The completion fall tick is also a legal grant point, so frames
        // can follow each other with no idle bit.
        free_slot = (state_q == S_IDLE) || (state_q == S_DATA && cnt_q == 16'd15);
        start     = fall_tick & free_slot & (REQ0_VALID | REQ1_VALID);
        gnt1      = REQ1_VALID & (~REQ0_VALID | ~last_q);
        if (gnt1)
            new_frame = {2'b01, (REQ1_RW ? 2'b01 : 2'b10), REQ1_PHY, REQ1_REG, 2'b10, REQ1_WDATA};
        else
            new_frame = {2'b01, (REQ0_RW ? 2'b01 : 2'b10), REQ0_PHY, REQ0_REG, 2'b10, REQ0_WDATA};
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            mdc_q   <= 1'b0;
            cnt_q   <= '0;
            frame_q <= '0;
            rw_q    <= 1'b0;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            rsh_q   <= '0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            div_q  <= wrap ? '0 : div_q + 1'b1;
            if (wrap)
                mdc_q <= ~mdc_q;
            if (rise_tick && state_q == S_DATA && !rw_q)
                rsh_q <= {rsh_q[14:0], MDIO_IN};

            if (fall_tick) begin
                case (state_q)
                    S_PRE: begin
                        if (cnt_q == PRE_LAST) begin
                            state_q <= S_HDR;
                            cnt_q   <= '0;
                            out_q   <= frame_q[31];
                            frame_q <= {frame_q[30:0], 1'b0};
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_HDR: begin
                        if (cnt_q == 16'd13) begin
                            state_q <= S_TA;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // Header bits are always driven; at the TA boundary a
                        // read hands the bus to the PHY.
                        if (cnt_q != 16'd13 || rw_q) begin
                            out_q   <= frame_q[31];
                            frame_q <= {frame_q[30:0], 1'b0};
                        end else begin
                            out_q <= 1'b0;
                            oe_q  <= 1'b0;
                        end
                    end
                    S_TA, S_DATA: begin
                        if (state_q == S_DATA && cnt_q == 16'd15) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            out_q   <= 1'b0;
                            oe_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            if (port_q) begin
                                rv1_q <= 1'b1;
                                rd1_q <= rw_q ? 16'd0 : rsh_q;
                            end else begin
                                rv0_q <= 1'b1;
                                rd0_q <= rw_q ? 16'd0 : rsh_q;
                            end
                        end else begin
                            if (state_q == S_TA && cnt_q == 16'd1) begin
                                state_q <= S_DATA;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                            if (rw_q) begin
                                out_q   <= frame_q[31];
                                frame_q <= {frame_q[30:0], 1'b0};
                            end else begin
                                out_q <= 1'b0;
                                oe_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase

                // A grant overrides the completion's return to idle.
                if (start) begin
                    port_q <= gnt1;
                    last_q <= gnt1;
                    rw_q   <= gnt1 ? REQ1_RW : REQ0_RW;
                    rdy0_q <= ~gnt1;
                    rdy1_q <= gnt1;
                    busy_q <= 1'b1;
                    oe_q   <= 1'b1;
                    cnt_q  <= '0;
                    if (PREAMBLE_LEN > 0) begin
                        state_q <= S_PRE;
                        out_q   <= 1'b1;
                        frame_q <= new_frame;
                    end else begin
                        state_q <= S_HDR;
                        out_q   <= new_frame[31];
                        frame_q <= {new_frame[30:0], 1'b0};
                    end
                end
            end
        end
    end

    assign MDC        = mdc_q;
    assign MDIO_OUT   = out_q;
    assign MDIO_OE    = oe_q;
    assign BUSY       = busy_q;
    assign REQ0_READY = rdy0_q;
    assign REQ1_READY = rdy1_q;
    assign RSP0_VALID = rv0_q;
    assign RSP1_VALID = rv1_q;
    assign RSP0_RDATA = rd0_q;
    assign RSP1_RDATA = rd1_q;
endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// Testbench for mdio_mgmt_ctrl. Two instances share the request inputs:
// dut_a (no preamble) and dut_b (32-bit preamble); sel_b picks which one is
// driven and observed.
module tb_mdio_mgmt_ctrl;
    localparam int DH = 2;
    localparam int P  = 2 * DH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel_b, mdio_in;
    logic        v0, v1, rw0, rw1;
    logic [4:0]  phy0, phy1, rg0, rg1;
    logic [15:0] wd0, wd1;

    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_mdc, a_out, a_oe, a_busy;
    logic [15:0] a_rd0, a_rd1;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_mdc, b_out, b_oe, b_busy;
    logic [15:0] b_rd0, b_rd1;

    logic        rdy0, rdy1, rsp0, rsp1, mdc, out, oe, busy;
    logic [15:0] rd0, rd1;
    assign rdy0 = sel_b ? b_rdy0 : a_rdy0;
    assign rdy1 = sel_b ? b_rdy1 : a_rdy1;
    assign rsp0 = sel_b ? b_rv0  : a_rv0;
    assign rsp1 = sel_b ? b_rv1  : a_rv1;
    assign mdc  = sel_b ? b_mdc  : a_mdc;
    assign out  = sel_b ? b_out  : a_out;
    assign oe   = sel_b ? b_oe   : a_oe;
    assign busy = sel_b ? b_busy : a_busy;
    assign rd0  = sel_b ? b_rd0  : a_rd0;
    assign rd1  = sel_b ? b_rd1  : a_rd1;

    mdio_mgmt_ctrl #(.DIV_HALF(DH), .PREAMBLE_LEN(0)) dut_a (
        .CLK(clk), .reset(rst_n),
        .REQ0_VALID(v0 & ~sel_b), .REQ0_RW(rw0), .REQ0_PHY(phy0), .REQ0_REG(rg0), .REQ0_WDATA(wd0),
        .REQ0_READY(a_rdy0), .RSP0_VALID(a_rv0), .RSP0_RDATA(a_rd0),
        .REQ1_VALID(v1 & ~sel_b), .REQ1_RW(rw1), .REQ1_PHY(phy1), .REQ1_REG(rg1), .REQ1_WDATA(wd1),
        .REQ1_READY(a_rdy1), .RSP1_VALID(a_rv1), .RSP1_RDATA(a_rd1),
        .MDC(a_mdc), .MDIO_OUT(a_out), .MDIO_OE(a_oe), .MDIO_IN(mdio_in), .BUSY(a_busy)
    );

    mdio_mgmt_ctrl #(.DIV_HALF(DH), .PREAMBLE_LEN(32)) dut_b (
        .CLK(clk), .reset(rst_n),
        .REQ0_VALID(v0 & sel_b), .REQ0_RW(rw0), .REQ0_PHY(phy0), .REQ0_REG(rg0), .REQ0_WDATA(wd0),
        .REQ0_READY(b_rdy0), .RSP0_VALID(b_rv0), .RSP0_RDATA(b_rd0),
        .REQ1_VALID(v1 & sel_b), .REQ1_RW(rw1), .REQ1_PHY(phy1), .REQ1_REG(rg1), .REQ1_WDATA(wd1),
        .REQ1_READY(b_rdy1), .RSP1_VALID(b_rv1), .RSP1_RDATA(b_rd1),
        .MDC(b_mdc), .MDIO_OUT(b_out), .MDIO_OE(b_oe), .MDIO_IN(mdio_in), .BUSY(b_busy)
    );

    int checks = 0;
    int errors = 0;
    bit last_port = 1'b1;   // reference arbiter: last granted port

    // Reference round-robin decision.
    function automatic bit model_pick(input bit a0, input bit a1);
        if (a0 && a1) return ~last_port;
        return a1;
    endfunction

    // Reference frame: k-th bit on the wire, MSB first.
    function automatic bit exp_bit(input int k, input bit rw, input logic [4:0] phy,
                                   input logic [4:0] rg, input logic [15:0] wd, input int pre);
        logic [31:0] f;
        f = {2'b01, (rw ? 2'b01 : 2'b10), phy, rg, 2'b10, wd};
        if (k < pre) return 1'b1;
        if (!rw && k >= pre + 14) return 1'b0;
        return f[31 - (k - pre)];
    endfunction

    task automatic wait_ready(output bit gp, output bit ok);
        ok = 1'b0;
        gp = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (rdy0 || rdy1) begin
                ok = 1'b1;
                gp = rdy1;
            end
        end
    endtask

    // Single request on one port, checked bit by bit on MDC rising edges.
    task automatic run_frame(input bit port, input bit rw, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wd,
                             input logic [15:0] reply, input string name);
        bit gp, ok, eb, eo;
        int pre, L, k, bad;
        logic [15:0] got;
        pre = sel_b ? 32 : 0;
        L = (pre + 32) * P;
        @(negedge clk);
        if (port) begin rw1 = rw; phy1 = phy; rg1 = rg; wd1 = wd; v1 = 1'b1; end
        else      begin rw0 = rw; phy0 = phy; rg0 = rg; wd0 = wd; v0 = 1'b1; end
        wait_ready(gp, ok);
        v0 = 1'b0;
        v1 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ready: no grant within bound, required grant", name);
            return;
        end
        checks++;
        if (gp !== port) begin
            errors++;
            $display("FAIL %s grant_port: got %0d required %0d", name, gp, port);
        end
        if (!sel_b) last_port = port;
        bad = 0;
        for (int c = 0; c <= L; c++) begin
            if (c > 0) @(negedge clk);
            k = c / P;
            if (c == 1) begin
                checks++;
                if ((rdy0 | rdy1) !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_width: ready still high after one cycle, required 0", name);
                end
            end
            if (c % P == 0 && !rw && k >= pre + 16 && k < pre + 32)
                mdio_in = reply[pre + 31 - k];
            if (c % P == DH && k < pre + 32) begin
                eb = exp_bit(k, rw, phy, rg, wd, pre);
                eo = (k < pre + 14) || rw;
                checks++;
                if (mdc !== 1'b1 || out !== eb || oe !== eo || busy !== 1'b1) begin
                    errors++;
                    if (bad < 6)
                        $display("FAIL %s bit%0d: mdc=%b out=%b oe=%b busy=%b required mdc=1 out=%b oe=%b busy=1",
                                 name, k, mdc, out, oe, busy, eb, eo);
                    bad++;
                end
            end
            if (c < L && (rsp0 || rsp1)) begin
                checks++;
                errors++;
                $display("FAIL %s early_rsp: response at cycle %0d, required at %0d", name, c, L);
            end
        end
        got = port ? rd1 : rd0;
        checks++;
        if ({rsp1, rsp0} !== (port ? 2'b10 : 2'b01) || got !== (rw ? 16'h0000 : reply)) begin
            errors++;
            $display("FAIL %s response: rsp1/rsp0=%b%b rdata=%h required port %0d rdata=%h at cycle %0d",
                     name, rsp1, rsp0, got, port, (rw ? 16'h0000 : reply), L);
        end
        checks++;
        if (busy !== 1'b0 || oe !== 1'b0 || out !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b oe=%b out=%b required 0 0 0", name, busy, oe, out);
        end
        $display("txn %s port=%0d rw=%0d phy=%h reg=%h wdata=%h rdata=%h", name, port, rw, phy, rg, wd, got);
    endtask

    // Requests held on the enabled ports; port 0 writes, port 1 reads.
    task automatic test_stream(input bit en0, input bit en1, input int n, input string name);
        bit gp, ok, ep;
        int c, L;
        logic [15:0] got, exp_rd;
        L = 32 * P;
        mdio_in = 1'b1;
        @(negedge clk);
        rw0 = 1'b1; phy0 = 5'($urandom); rg0 = 5'($urandom); wd0 = 16'($urandom);
        rw1 = 1'b0; phy1 = 5'($urandom); rg1 = 5'($urandom); wd1 = 16'($urandom);
        v0 = en0;
        v1 = en1;
        wait_ready(gp, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ready: no grant within bound, required grant", name);
            v0 = 1'b0;
            v1 = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            ep = model_pick(en0, en1);
            last_port = ep;
            checks++;
            if (gp !== ep) begin
                errors++;
                $display("FAIL %s grant%0d: got port %0d required %0d", name, i, gp, ep);
            end
            c = 0;
            ok = 1'b0;
            while (c < L + 8 && !ok) begin
                @(negedge clk);
                c++;
                if (c == 1) begin
                    checks++;
                    if ((rdy0 | rdy1) !== 1'b0) begin
                        errors++;
                        $display("FAIL %s ready_width%0d: ready high after one cycle, required 0", name, i);
                    end
                end
                if (i == n - 1 && c == L - P) begin
                    v0 = 1'b0;
                    v1 = 1'b0;
                end
                if (rsp0 || rsp1) ok = 1'b1;
            end
            checks++;
            if (!ok || c != L) begin
                errors++;
                $display("FAIL %s latency%0d: got %0d cycles required %0d", name, i, c, L);
            end
            got = ep ? rd1 : rd0;
            exp_rd = ep ? 16'hFFFF : 16'h0000;
            checks++;
            if ({rsp1, rsp0} !== (ep ? 2'b10 : 2'b01) || got !== exp_rd) begin
                errors++;
                $display("FAIL %s rsp%0d: rsp1/rsp0=%b%b rdata=%h required port %0d rdata=%h",
                         name, i, rsp1, rsp0, got, ep, exp_rd);
            end
            $display("txn %s #%0d port=%0d rdata=%h", name, i, ep, got);
            checks++;
            if (i < n - 1) begin
                gp = rdy1;
                if ((rdy0 | rdy1) !== 1'b1 || oe !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s b2b%0d: ready=%b%b oe=%b busy=%b required a grant with oe=1 busy=1",
                             name, i, rdy1, rdy0, oe, busy);
                end
            end else if ((rdy0 | rdy1 | busy) !== 1'b0) begin
                errors++;
                $display("FAIL %s end: ready=%b%b busy=%b required all 0", name, rdy1, rdy0, busy);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_port = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mdc, out, oe, busy, rdy0, rdy1, rsp0, rsp1} !== 8'b0 || rd0 !== 16'h0 || rd1 !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: mdc,out,oe,busy,rdy,rsp=%b rd0=%h rd1=%h required all 0",
                     {mdc, out, oe, busy, rdy0, rdy1, rsp0, rsp1}, rd0, rd1);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (mdc !== 1'((n / DH) % 2)) begin
                errors++;
                $display("FAIL mdc_div cycle%0d: got %b required %b", n, mdc, 1'((n / DH) % 2));
            end
        end
        $display("txn reset done");
    endtask

    task automatic test_write();
        run_frame(1'b0, 1'b1, 5'b01000, 5'b10100, 16'h5555, 16'h0, "plan_write");
        for (int i = 0; i < 3; i++)
            run_frame(1'($urandom), 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, "rand_write");
    endtask

    task automatic test_read();
        run_frame(1'b1, 1'b0, 5'd8, 5'd20, 16'h0, 16'hAAAA, "plan_read");
        for (int i = 0; i < 3; i++)
            run_frame(1'($urandom), 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), "rand_read");
    endtask

    task automatic test_round_robin();
        apply_reset();
        test_stream(1'b1, 1'b1, 4, "round_robin");
    endtask

    task automatic test_back_to_back();
        test_stream(1'b1, 1'b0, 3, "back_to_back");
    endtask

    task automatic test_preamble();
        sel_b = 1'b1;
        run_frame(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, "preamble_write");
        run_frame(1'b1, 1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), "preamble_read");
        sel_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit gp, ok, seen;
        @(negedge clk);
        rw0 = 1'b0; phy0 = 5'($urandom); rg0 = 5'($urandom); v0 = 1'b1;
        wait_ready(gp, ok);
        v0 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid ready: no grant within bound, required grant");
        end
        repeat (20 * P + 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mdc, oe, out, busy, rsp0, rsp1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: mdc,oe,out,busy,rsp0,rsp1=%b required 000000",
                     {mdc, oe, out, busy, rsp0, rsp1});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_port = 1'b1;
        seen = 1'b0;
        repeat (32 * P) begin
            @(negedge clk);
            if (rsp0 || rsp1 || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid aborted: response or busy seen after abort, required none");
        end
        run_frame(1'b0, 1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel_b = 1'b0; mdio_in = 1'b0;
        v0 = 1'b0; v1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        phy0 = '0; phy1 = '0; rg0 = '0; rg1 = '0; wd0 = '0; wd1 = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_back_to_back();
        test_preamble();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
